alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The parameter list SHALL be: HOLD_CYCLES, 1, EXEC-state cycles ALUOp is held before result capture (legal 1..15).
REQ-002 The ports SHALL be, one per line:
  Clk  input  1  sole clock, rising edge
  Clear  input  1  asynchronous active-low reset (0 = reset)
  Req0  input  1  requester 0 wants an add
  A0  input  8  requester 0 operand 1
  B0  input  8  requester 0 operand 2
  Req1  input  1  requester 1 wants an add
  A1  input  8  requester 1 operand 1
  B1  input  8  requester 1 operand 2
  Gnt0  output  1  requester 0 granted, operands sampled this cycle
  Gnt1  output  1  requester 1 granted, operands sampled this cycle
  Done0  output  1  one-cycle pulse, Result valid for requester 0
  Done1  output  1  one-cycle pulse, Result valid for requester 1
  Result  output  8  registered sum of last completed op
  ALUOp  output  1  to shared ALU, 1 = add enabled
  AluData1  output  8  to shared ALU operand 1
  AluData2  output  8  to shared ALU operand 2
  AluClear  output  1  to shared ALU clear, active-high
  AluResult  input  8  from shared ALU, combinational sum

Function
REQ-003 The FSM SHALL have states IDLE, EXEC, DONE; IDLE->EXEC on grant, EXEC->DONE when hold counter reaches 0, DONE->IDLE unconditionally.
REQ-004 In IDLE with any Req high, exactly one Gnt SHALL assert combinationally that cycle; operands of the winner, winner index and counter = HOLD_CYCLES-1 SHALL be registered at the clock edge.
REQ-005 Gnt0/Gnt1 SHALL be 0 in EXEC and DONE, and never both 1.
REQ-006 Arbitration (default) SHALL be round-robin: when both Req high, grant the requester not served last; a lone requester is always granted.
REQ-007 In EXEC, ALUOp SHALL be 1, AluClear 0, AluData1/AluData2 driven from the operand registers; counter decrements each EXEC cycle.
REQ-008 On the EXEC cycle with counter 0, AluResult SHALL be captured into Result at the edge.
REQ-009 In DONE, only the winner's Done SHALL be 1 for exactly one cycle.
REQ-010 Outside EXEC, ALUOp SHALL be 0, AluClear 1, AluData1/AluData2 0.
REQ-011 Latency: grant in cycle T, Done in cycle T+HOLD_CYCLES+1; next grant earliest T+HOLD_CYCLES+2.
REQ-012 Result SHALL hold its value until the next capture; addition wraps modulo 256, no carry output.
REQ-013 Req or operand changes after the grant cycle SHALL not affect the in-flight op.

Reset
REQ-014 Clear=0 SHALL asynchronously force IDLE, Result=0, Done0=Done1=0, counter=0, operand registers 0, last-served pointer=1 (so requester 0 wins the first tie).
REQ-015 Clear asserted mid-operation SHALL abort it with no Done pulse and no Result update.
REQ-016 After Clear returns to 1, the first grant SHALL occur no earlier than the next rising edge.

Configuration
REQ-017 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins ties, pointer unused; undefined -> round-robin per REQ-006.

Structure
REQ-018 Package alu_arb_pkg SHALL hold the state enum (IDLE/EXEC/DONE), DATA_W=8 and HOLD_CYCLES default.
REQ-019 Winner selection SHALL be one sub-module alu_arb_pick (inputs Req0, Req1, pointer; outputs grant vector); the ALU itself stays external.

Verification
REQ-020 Req0=1, A0=0x12, B0=0x34, HOLD_CYCLES=1 -> Gnt0 at T, ALUOp=1 at T+1, Done0 and Result=0x46 at T+2.
REQ-021 A1=0xFF, B1=0x02 via requester 1 -> Result=0x01, Done1 only.
REQ-022 Req0=Req1=1 held continuously -> grants alternate 0,1,0,1 from reset; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-023 HOLD_CYCLES=3, single request -> ALUOp high 3 cycles, Done at T+4, AluClear low only during EXEC.
REQ-024 Clear=0 in EXEC -> immediate IDLE, Result=0, no Done; subsequent Req1 served normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and sizing for the two-requester ALU arbiter.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W = 4;
    localparam int HOLD_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle for the link between the arbiter and the shared external ALU.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (not used here).
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic              op;
    logic              clear;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] result;

    modport master (
        output op, clear, data1, data2,
        input  result
    );

    modport slave (
        input  op, clear, data1, data2,
        output result
    );

endinterface

// File: rtl/alu_arb_pick.sv
// Winner selection between two requesters.
// ALU_ARB_FIXED_PRIO_EN: ties go to requester 0; otherwise round-robin.
module alu_arb_pick (
    input  logic       Req0,
    input  logic       Req1,
    input  logic       pointer,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_pointer;
    assign unused_pointer = pointer;
`endif

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (Req0 && Req1): begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                gnt = 2'b01;
`else
                // pointer holds the last served index
                gnt = pointer ? 2'b01 : 2'b10;
`endif
            end
            (Req0 && !Req1): gnt = 2'b01;
            (!Req0 && Req1): gnt = 2'b10;
            default:         gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external combinational adder.
// ALU_ARB_FIXED_PRIO_EN: fixed priority to requester 0 instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              Req0,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] B0,
    input  logic              Req1,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] B1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Done0,
    output logic              Done1,
    output logic [DATA_W-1:0] Result,
    output logic              ALUOp,
    output logic [DATA_W-1:0] AluData1,
    output logic [DATA_W-1:0] AluData2,
    output logic              AluClear,
    input  logic [DATA_W-1:0] AluResult
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] result_q;
    logic [1:0]        done_q;
    logic              win;
    logic              last;
    logic              op_q;
    logic [1:0]        pick;
    logic [1:0]        gnt;

    alu_arb_pick u_pick (
        .Req0    (Req0),
        .Req1    (Req1),
        .pointer (last),
        .gnt     (pick)
    );

    assign gnt = (state == IDLE) ? pick : 2'b00;

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            result_q <= '0;
            done_q   <= 2'b00;
            win      <= 1'b0;
            last     <= 1'b1;
            op_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 2'b00;
                    if (|gnt) begin
                        state <= EXEC;
                        op_q  <= 1'b1;
                        win   <= gnt[1];
                        last  <= gnt[1];
                        opa   <= gnt[1] ? A1 : A0;
                        opb   <= gnt[1] ? B1 : B0;
                        cnt   <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        op_q     <= 1'b0;
                        result_q <= AluResult;
                        done_q   <= win ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 2'b00;
                end
                default: begin
                    state  <= IDLE;
                    op_q   <= 1'b0;
                    done_q <= 2'b00;
                end
            endcase
        end
    end

    assign Gnt0     = gnt[0];
    assign Gnt1     = gnt[1];
    assign Done0    = done_q[0];
    assign Done1    = done_q[1];
    assign Result   = result_q;
    assign ALUOp    = op_q;
    assign AluClear = ~op_q;
    assign AluData1 = op_q ? opa : '0;
    assign AluData2 = op_q ? opb : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: two arbiters (hold 1 and hold 3) with adder models.
// ALU_ARB_FIXED_PRIO_EN selects the fixed-priority tie expectations.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic clear;
    logic r0, r1, q0, q1;
    logic [7:0] a0, b0, a1, b1;
    logic [7:0] qa0, qb0, qa1, qb1;
    logic g0, g1, dn0, dn1, op1, clr1;
    logic g0_3, g1_3, dn0_3, dn1_3, op3, clr3;
    logic [7:0] res, res3;
    logic exp0;
    int n_chk = 0;
    int n_fail = 0;

    alu_arbiter_if bus1 ();
    alu_arbiter_if bus3 ();

    assign bus1.result = bus1.data1 + bus1.data2;
    assign bus3.result = bus3.data1 + bus3.data2;
    assign bus1.op = op1;
    assign bus1.clear = clr1;
    assign bus3.op = op3;
    assign bus3.clear = clr3;

    always #5 clk = ~clk;

    alu_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .Clk(clk), .Clear(clear),
        .Req0(r0), .A0(a0), .B0(b0),
        .Req1(r1), .A1(a1), .B1(b1),
        .Gnt0(g0), .Gnt1(g1),
        .Done0(dn0), .Done1(dn1),
        .Result(res), .ALUOp(op1),
        .AluData1(bus1.data1), .AluData2(bus1.data2),
        .AluClear(clr1), .AluResult(bus1.result)
    );

    alu_arbiter #(.HOLD_CYCLES(3)) dut3 (
        .Clk(clk), .Clear(clear),
        .Req0(q0), .A0(qa0), .B0(qb0),
        .Req1(q1), .A1(qa1), .B1(qb1),
        .Gnt0(g0_3), .Gnt1(g1_3),
        .Done0(dn0_3), .Done1(dn1_3),
        .Result(res3), .ALUOp(op3),
        .AluData1(bus3.data1), .AluData2(bus3.data2),
        .AluClear(clr3), .AluResult(bus3.result)
    );

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    initial begin
        clear = 1'b0;
        r0 = 0; r1 = 0; q0 = 0; q1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        qa0 = 0; qb0 = 0; qa1 = 0; qb1 = 0;

        // reset state
        @(negedge clk); #1;
        chk("rst_res", res, 8'h00);
        chk("rst_done", {6'd0, dn1, dn0}, 8'h00);
        chk("rst_aluop", {7'd0, op1}, 8'h00);
        chk("rst_aluclr", {7'd0, clr1}, 8'h01);
        chk("rst_data1", bus1.data1, 8'h00);
        chk("rst3_res", res3, 8'h00);

        // requester 0, hold 1
        @(negedge clk);
        clear = 1'b1;
        r0 = 1; a0 = 8'h12; b0 = 8'h34;
        #1;
        chk("r0_gnt", {6'd0, g1, g0}, 8'h01);
        @(negedge clk);
        r0 = 0; a0 = 8'hAA;
        #1;
        chk("r0_aluop", {7'd0, op1}, 8'h01);
        chk("r0_aluclr", {7'd0, clr1}, 8'h00);
        chk("r0_d1", bus1.data1, 8'h12);
        chk("r0_d2", bus1.data2, 8'h34);
        chk("r0_exec_gnt", {6'd0, g1, g0}, 8'h00);
        chk("r0_exec_done", {6'd0, dn1, dn0}, 8'h00);
        @(negedge clk); #1;
        chk("r0_done", {6'd0, dn1, dn0}, 8'h01);
        chk("r0_res", res, 8'h46);
        chk("r0_done_aluop", {7'd0, op1}, 8'h00);
        chk("r0_done_d1", bus1.data1, 8'h00);
        chk("r0_done_gnt", {6'd0, g1, g0}, 8'h00);

        // requester 1, wrapping sum
        @(negedge clk);
        r1 = 1; a1 = 8'hFF; b1 = 8'h02;
        #1;
        chk("r0_pulse_end", {6'd0, dn1, dn0}, 8'h00);
        chk("r0_res_hold", res, 8'h46);
        chk("r1_gnt", {6'd0, g1, g0}, 8'h02);
        @(negedge clk);
        r1 = 0;
        #1;
        chk("r1_d1", bus1.data1, 8'hFF);
        @(negedge clk); #1;
        chk("r1_done", {6'd0, dn1, dn0}, 8'h02);
        chk("r1_res", res, 8'h01);

        // ties from a fresh reset
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_res", res, 8'h00);
        @(negedge clk);
        clear = 1'b1;
        r0 = 1; r1 = 1;
        a0 = 8'h12; b0 = 8'h34;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (k % 2 == 0);
`endif
            chk("tie_gnt", {6'd0, g1, g0},
                exp0 ? 8'h01 : 8'h02);
            @(negedge clk); #1;
            chk("tie_exec_gnt", {6'd0, g1, g0}, 8'h00);
            @(negedge clk); #1;
            chk("tie_done", {6'd0, dn1, dn0},
                exp0 ? 8'h01 : 8'h02);
            chk("tie_res", res, exp0 ? 8'h46 : 8'h01);
            chk("tie_done_gnt", {6'd0, g1, g0}, 8'h00);
        end
        @(negedge clk);
        r0 = 0; r1 = 0;
        #1;
        chk("idle_gnt", {6'd0, g1, g0}, 8'h00);

        // abort mid-EXEC
        @(negedge clk);
        r0 = 1; a0 = 8'h10; b0 = 8'h20;
        #1;
        chk("ab_gnt", {6'd0, g1, g0}, 8'h01);
        @(negedge clk);
        r0 = 0;
        #1;
        chk("ab_exec", {7'd0, op1}, 8'h01);
        clear = 1'b0;
        #1;
        chk("ab_aluop", {7'd0, op1}, 8'h00);
        chk("ab_aluclr", {7'd0, clr1}, 8'h01);
        chk("ab_res", res, 8'h00);
        chk("ab_done", {6'd0, dn1, dn0}, 8'h00);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("ab_nodone", {6'd0, dn1, dn0}, 8'h00);
        chk("ab_res_hold", res, 8'h00);
        @(negedge clk);
        r1 = 1; a1 = 8'hFF; b1 = 8'h02;
        #1;
        chk("ab_r1_gnt", {6'd0, g1, g0}, 8'h02);
        @(negedge clk);
        r1 = 0;
        @(negedge clk); #1;
        chk("ab_r1_done", {6'd0, dn1, dn0}, 8'h02);
        chk("ab_r1_res", res, 8'h01);

        // hold 3
        @(negedge clk);
        q0 = 1; qa0 = 8'h05; qb0 = 8'h07;
        #1;
        chk("h3_gnt", {6'd0, g1_3, g0_3}, 8'h01);
        chk("h3_gnt_clr", {7'd0, clr3}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            q0 = 0;
            #1;
            chk("h3_aluop", {7'd0, op3}, 8'h01);
            chk("h3_aluclr", {7'd0, clr3}, 8'h00);
            chk("h3_nodone", {6'd0, dn1_3, dn0_3}, 8'h00);
        end
        @(negedge clk); #1;
        chk("h3_done", {6'd0, dn1_3, dn0_3}, 8'h01);
        chk("h3_res", res3, 8'h0C);
        chk("h3_done_aluop", {7'd0, op3}, 8'h00);
        chk("h3_done_clr", {7'd0, clr3}, 8'h01);
        @(negedge clk); #1;
        chk("h3_pulse_end", {6'd0, dn1_3, dn0_3}, 8'h00);
        chk("h3_res_hold", res3, 8'h0C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
